div_unsigned_core_seq: RTL

//  Sequential 32-bit signed divider: the DIV half of the multdiv unit, run beside the Booth multiplier.

---
 rtl/div_unsigned_core_seq_pkg.sv | 14 +
 rtl/div_unsigned_core_seq_step.sv | 31 +++
 rtl/div_unsigned_core_seq.sv | 127 ++++++++++++
 3 files changed

// File: rtl/div_unsigned_core_seq_pkg.sv
// Shared definitions for the sequential divider: default widths and FSM states.
package div_unsigned_core_seq_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_unsigned_core_seq_step.sv
// One restoring-division step on magnitudes: shift {R,Q} left, trial-subtract |B|,
// keep the difference and set the quotient bit when it does not borrow.
module div_unsigned_core_seq_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] mag_b,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] quo_sh;
  logic [WIDTH+1:0] trial;

  // Shift, trial subtract with an extra top bit that acts as the borrow flag.
  always_comb begin
    rem_sh = {rem_in[WIDTH-1:0], quo_in[WIDTH-1]};
    quo_sh = {quo_in[WIDTH-2:0], 1'b0};
    trial  = {1'b0, rem_sh} - {2'b00, mag_b};
    if (trial[WIDTH+1]) begin
      rem_out = rem_sh;
      quo_out = quo_sh;
    end else begin
      rem_out = trial[WIDTH:0];
      quo_out = {quo_sh[WIDTH-1:1], 1'b1};
    end
  end

endmodule

// File: rtl/div_unsigned_core_seq.sv
// Sequential signed divider: restoring radix-2 on magnitudes, one quotient bit per
// cycle, sign fix-up in a final cycle. Fixed 33-edge latency from ctrl_DIV to rdy.
module div_unsigned_core_seq
  import div_unsigned_core_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic             ctrl_DIV,
  input  logic             ctrl_MULT,
  output logic [WIDTH-1:0] result,
  output logic             exception,
  output logic             rdy
);

  localparam logic [CNT_W-1:0] ITER_CNT = CNT_W'(WIDTH);
  localparam logic [WIDTH-1:0] INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  div_state_t       state, state_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;
  logic [WIDTH:0]   rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] mag_b;
  logic             sign_q;
  logic             dz;
  logic             ovf;
  logic [WIDTH-1:0] mag_a_in;
  logic [WIDTH-1:0] mag_b_in;
  logic [WIDTH:0]   rem_step;
  logic [WIDTH-1:0] quo_step;

  // Magnitudes of the incoming operands; INT_MIN maps to 2^(WIDTH-1) unsigned.
  always_comb begin
    mag_a_in  = dataA[WIDTH-1] ? -dataA : dataA;
    mag_b_in  = dataB[WIDTH-1] ? -dataB : dataB;
    count_inc = count + CNT_W'(1);
  end

  div_unsigned_core_seq_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_r),
    .quo_in  (quo_r),
    .mag_b   (mag_b),
    .rem_out (rem_step),
    .quo_out (quo_step)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: MULT aborts, DIV (re)starts, otherwise walk RUN -> FIX -> DONE.
  // NOTE: state_nxt is defaulted first so every path assigns it and no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (ctrl_MULT) begin
      state_nxt = ST_IDLE;
    end else if (ctrl_DIV) begin
      state_nxt = ST_RUN;
    end else begin
      unique case (state)
        ST_IDLE: state_nxt = ST_IDLE;
        ST_RUN:  if (count_inc == ITER_CNT) state_nxt = ST_FIX;
        ST_FIX:  state_nxt = ST_DONE;
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Datapath: operand latch on start, one step per RUN edge, sign/flag fix-up in FIX.
  // NOTE: all registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count     <= '0;
      rem_r     <= '0;
      quo_r     <= '0;
      mag_b     <= '0;
      sign_q    <= 1'b0;
      dz        <= 1'b0;
      ovf       <= 1'b0;
      result    <= '0;
      exception <= 1'b0;
      rdy       <= 1'b0;
    end else if (ctrl_MULT) begin
      count     <= '0;
      result    <= '0;
      exception <= 1'b0;
      rdy       <= 1'b0;
    end else if (ctrl_DIV) begin
      count  <= '0;
      rem_r  <= '0;
      quo_r  <= mag_a_in;
      mag_b  <= mag_b_in;
      sign_q <= dataA[WIDTH-1] ^ dataB[WIDTH-1];
      dz     <= (dataB == '0);
      ovf    <= (dataA == INT_MIN) && (dataB == ALL_ONES);
      rdy    <= 1'b0;
    end else begin
      unique case (state)
        ST_RUN: begin
          rem_r <= rem_step;
          quo_r <= quo_step;
          count <= count_inc;
        end
        ST_FIX: begin
          if (ovf)         result <= INT_MIN;
          else if (dz)     result <= '0;
          else if (sign_q) result <= -quo_r;
          else             result <= quo_r;
          exception <= dz | ovf;
          rdy       <= 1'b1;
        end
        ST_DONE: rdy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
